// File: rtl/mips_cpu_lsu.sv
// Load/store unit: turns core byte/half/word requests into single Avalon-MM
// word transactions. It handles lane steering, load extension, alignment
// faults and a bounded waitrequest timeout.
module mips_cpu_lsu #(
  parameter int unsigned MAX_WAIT    = 16,
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned WAIT_W = 32;

  typedef enum logic [1:0] {IDLE, BUS, RDATA, RESP} state_t;

  state_t              state;
  logic                lat_write;
  logic                lat_signed;
  logic [1:0]          lat_size;
  logic [1:0]          lat_off;
  logic [WAIT_W-1:0]   wait_cnt;

  logic                fault_c;
  logic [1:0]          off_c;
  logic [BE_W-1:0]     be_c;
  logic [DATA_W-1:0]   wdata_c;
  logic [7:0]          lane_b_c;
  logic [15:0]         lane_h_c;
  logic [DATA_W-1:0]   ext_c;

  // Decode the incoming request: fault, effective byte offset, lanes, store data.
  always_comb begin
    fault_c = 1'b0;
    off_c   = req_addr[1:0];
    be_c    = '0;
    wdata_c = req_wdata;
    case (req_size)
      2'd0: begin
        be_c    = BE_W'(4'b0001 << req_addr[1:0]);
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        off_c   = {req_addr[1], 1'b0};
        be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_wdata[15:0]}};
        fault_c = (ALIGN_CHECK != 0) && req_addr[0];
      end
      2'd2: begin
        off_c   = 2'b00;
        be_c    = 4'b1111;
        fault_c = (ALIGN_CHECK != 0) && (req_addr[1:0] != 2'b00);
      end
      default: fault_c = 1'b1;
    endcase
  end

  // Pick the loaded lane(s) by the latched offset and extend to 32 bits.
  always_comb begin
    lane_b_c = readdata[7:0];
    case (lat_off)
      2'd0: lane_b_c = readdata[7:0];
      2'd1: lane_b_c = readdata[15:8];
      2'd2: lane_b_c = readdata[23:16];
      default: lane_b_c = readdata[31:24];
    endcase
    lane_h_c = lat_off[1] ? readdata[31:16] : readdata[15:0];
    case (lat_size)
      2'd0:    ext_c = {{24{lat_signed & lane_b_c[7]}}, lane_b_c};
      2'd1:    ext_c = {{16{lat_signed & lane_h_c[15]}}, lane_h_c};
      default: ext_c = readdata;
    endcase
  end

  // Transaction FSM with registered core and bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      lat_write  <= 1'b0;
      lat_signed <= 1'b0;
      lat_size   <= 2'd0;
      lat_off    <= 2'd0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            lat_write  <= req_write;
            lat_signed <= req_signed;
            lat_size   <= req_size;
            lat_off    <= off_c;
            wait_cnt   <= '0;
            if (fault_c) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state      <= BUS;
              read       <= ~req_write;
              write      <= req_write;
              address    <= {req_addr[31:2], 2'b00};
              writedata  <= wdata_c;
              byteenable <= be_c;
            end
          end
        end
        BUS: begin
          if (waitrequest) begin
            if ((MAX_WAIT != 0) && (wait_cnt + WAIT_W'(1) == WAIT_W'(MAX_WAIT))) begin
              state      <= RESP;
              read       <= 1'b0;
              write      <= 1'b0;
              address    <= '0;
              writedata  <= '0;
              byteenable <= '0;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end else begin
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            if (lat_write) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= '0;
            end else begin
              state <= RDATA;
            end
          end
        end
        RDATA: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= ext_c;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Bench for mips_cpu_lsu: directed vector table, reset-in-flight sequence and
// randomized transactions checked against a behavioural model.
// Instance 0: MAX_WAIT=4, ALIGN_CHECK=1. Instance 1: MAX_WAIT=0, ALIGN_CHECK=0.
module tb_mips_cpu_lsu;

  logic clk = 1'b0;
  logic reset;

  logic        rv[2], rw[2], rsg[2], wreq[2];
  logic [1:0]  rsz[2];
  logic [31:0] ra[2], rwd[2], rdat[2];
  logic        rdy[2], rsv[2], rer[2], rd[2], wro[2];
  logic [31:0] rrd[2], adr[2], wd[2];
  logic [3:0]  be[2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_cpu_lsu #(.MAX_WAIT(4), .ALIGN_CHECK(1)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(rw[0]), .req_size(rsz[0]),
    .req_signed(rsg[0]), .req_addr(ra[0]), .req_wdata(rwd[0]),
    .resp_valid(rsv[0]), .resp_rdata(rrd[0]), .resp_err(rer[0]),
    .address(adr[0]), .read(rd[0]), .write(wro[0]), .waitrequest(wreq[0]),
    .writedata(wd[0]), .byteenable(be[0]), .readdata(rdat[0])
  );

  mips_cpu_lsu #(.MAX_WAIT(0), .ALIGN_CHECK(0)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(rw[1]), .req_size(rsz[1]),
    .req_signed(rsg[1]), .req_addr(ra[1]), .req_wdata(rwd[1]),
    .resp_valid(rsv[1]), .resp_rdata(rrd[1]), .resp_err(rer[1]),
    .address(adr[1]), .read(rd[1]), .write(wro[1]), .waitrequest(wreq[1]),
    .writedata(wd[1]), .byteenable(be[1]), .readdata(rdat[1])
  );

  typedef struct {
    int          d;
    bit          wr;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brd;
    int          nwait;
    int          lat;
    bit          err;
    logic [31:0] rdata;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          bus_n;
  } vec_t;

  localparam int unsigned NVEC = 18;
  vec_t vt[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one request on instance d and act as the Avalon slave; observe the outcome.
  task automatic run_txn(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] brd, input int nwait, input bit noise,
                         output int lat, output int bus_n, output bit err,
                         output logic [31:0] rdata, output logic [31:0] baddr,
                         output logic [3:0] bbe, output logic [31:0] bwd,
                         output bit stable, output bit hs_ok);
    bit done;
    bit rd_pend;
    lat = -1; bus_n = 0; err = 1'b0; rdata = '0; baddr = '0; bbe = '0; bwd = '0;
    stable = 1'b1;
    hs_ok = (rdy[d] === 1'b1);
    rv[d] = 1'b1; rw[d] = wr; rsz[d] = sz; rsg[d] = sg; ra[d] = addr; rwd[d] = wdata;
    rd_pend = 1'b0;
    done = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(posedge clk); #1;
      rv[d] = noise;
      if (noise) begin
        rw[d] = 1'($urandom); rsz[d] = 2'($urandom); rsg[d] = 1'($urandom);
        ra[d] = $urandom; rwd[d] = $urandom;
      end
      rdat[d] = rd_pend ? brd : $urandom;
      rd_pend = 1'b0;
      wreq[d] = 1'b0;
      if (rd[d] || wro[d]) begin
        if (bus_n == 0) begin
          baddr = adr[d]; bbe = be[d]; bwd = wd[d];
        end else if (adr[d] !== baddr || be[d] !== bbe || wd[d] !== bwd) begin
          stable = 1'b0;
        end
        bus_n++;
        if (nwait < 0 || bus_n <= nwait) wreq[d] = 1'b1;
        else if (rd[d]) rd_pend = 1'b1;
      end
      if (rdy[d] !== 1'b0) hs_ok = 1'b0;
      if (rsv[d] === 1'b1) begin
        lat = cyc; err = rer[d]; rdata = rrd[d]; done = 1'b1;
      end
    end
    rv[d] = 1'b0;
    wreq[d] = 1'b0;
    if (done) begin
      @(posedge clk); #1;
      if (rdy[d] !== 1'b1 || rsv[d] !== 1'b0) hs_ok = 1'b0;
    end
  endtask

  // Reference behaviour computed from the access rules with plain arithmetic.
  function automatic void model(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] brd, input int nwait,
                                output int lat, output int bus_n, output bit err,
                                output logic [31:0] rdata, output logic [31:0] baddr,
                                output logic [3:0] bbe, output logic [31:0] bwd);
    int nb, off, a2, mw;
    bit align;
    longint unsigned val, mask;
    align = (d == 0);
    mw = (d == 0) ? 4 : 0;
    rdata = '0; baddr = '0; bbe = '0; bwd = '0; err = 1'b0;
    a2 = int'(addr[1:0]);
    nb = 1 << sz;
    if (sz == 2'd3 || (align && (a2 % nb) != 0)) begin
      err = 1'b1; lat = 1; bus_n = 0;
      return;
    end
    off = a2 - (a2 % nb);
    baddr = addr - 32'(a2);
    bbe = 4'(((1 << nb) - 1) << off);
    for (int l = 0; l < 4; l++) bwd[8*l +: 8] = wdata[8*(l % nb) +: 8];
    if (mw != 0 && (nwait < 0 || nwait >= mw)) begin
      err = 1'b1; lat = 1 + mw; bus_n = mw;
      return;
    end
    bus_n = nwait + 1;
    if (wr) begin
      lat = 2 + nwait;
    end else begin
      lat = 3 + nwait;
      mask = (64'd1 << (8 * nb)) - 64'd1;
      val = ({32'd0, brd} >> (8 * off)) & mask;
      if (sg && val[8*nb-1]) val = val | ~mask;
      rdata = val[31:0];
    end
  endfunction

  int          o_lat, o_bus;
  bit          o_err, o_stable, o_hs;
  logic [31:0] o_rdata, o_addr, o_wd;
  logic [3:0]  o_be;
  int          e_lat, e_bus;
  bit          e_err;
  logic [31:0] e_rdata, e_addr, e_wd;
  logic [3:0]  e_be;

  task automatic compare_all(input string tag, input bit wr);
    check({tag, " latency"}, 32'(o_lat), 32'(e_lat));
    check({tag, " err"}, 32'(o_err), 32'(e_err));
    check({tag, " rdata"}, o_rdata, e_rdata);
    check({tag, " bus_cycles"}, 32'(o_bus), 32'(e_bus));
    check({tag, " handshake"}, 32'(o_hs), 32'd1);
    if (e_bus > 0) begin
      check({tag, " address"}, o_addr, e_addr);
      check({tag, " byteenable"}, 32'(o_be), 32'(e_be));
      check({tag, " bus_stable"}, 32'(o_stable), 32'd1);
      if (wr) check({tag, " writedata"}, o_wd, e_wd);
    end
  endtask

  initial begin
    vt[0]  = '{0, 1'b1, 2'd0, 1'b0, 32'h1003, 32'h000000A5, 32'h0, 0, 2, 1'b0, 32'h0, 32'h1000, 4'b1000, 32'hA5A5A5A5, 1};
    vt[1]  = '{0, 1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h80011234, 0, 3, 1'b0, 32'hFFFF8001, 32'h2000, 4'b1100, 32'h0, 1};
    vt[2]  = '{0, 1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h80011234, 0, 3, 1'b0, 32'h00008001, 32'h2000, 4'b1100, 32'h0, 1};
    vt[3]  = '{0, 1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 32'hDEADBEEF, 3, 6, 1'b0, 32'hDEADBEEF, 32'h3000, 4'b1111, 32'h0, 4};
    vt[4]  = '{0, 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h11111111, 0, 1, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 0};
    vt[5]  = '{1, 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h12345678, 0, 3, 1'b0, 32'h12345678, 32'h3000, 4'b1111, 32'h0, 1};
    vt[6]  = '{0, 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, -1, 5, 1'b1, 32'h0, 32'h4000, 4'b1111, 32'h0, 4};
    vt[7]  = '{0, 1'b0, 2'd3, 1'b0, 32'h4000, 32'h0, 32'h0, 0, 1, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 0};
    vt[8]  = '{0, 1'b0, 2'd0, 1'b1, 32'h5001, 32'h0, 32'h00008000, 0, 3, 1'b0, 32'hFFFFFF80, 32'h5000, 4'b0010, 32'h0, 1};
    vt[9]  = '{0, 1'b0, 2'd0, 1'b0, 32'h5003, 32'h0, 32'hF1000000, 0, 3, 1'b0, 32'h000000F1, 32'h5000, 4'b1000, 32'h0, 1};
    vt[10] = '{0, 1'b1, 2'd1, 1'b0, 32'h6002, 32'h1234BEEF, 32'h0, 0, 2, 1'b0, 32'h0, 32'h6000, 4'b1100, 32'hBEEFBEEF, 1};
    vt[11] = '{0, 1'b1, 2'd2, 1'b0, 32'h7004, 32'hCAFEF00D, 32'h0, 2, 4, 1'b0, 32'h0, 32'h7004, 4'b1111, 32'hCAFEF00D, 3};
    vt[12] = '{0, 1'b1, 2'd1, 1'b0, 32'h6001, 32'h00000001, 32'h0, 0, 1, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 0};
    vt[13] = '{1, 1'b1, 2'd1, 1'b0, 32'h6003, 32'h00005A5A, 32'h0, 0, 2, 1'b0, 32'h0, 32'h6000, 4'b1100, 32'h5A5A5A5A, 1};
    vt[14] = '{1, 1'b0, 2'd1, 1'b1, 32'h6001, 32'h0, 32'h0000F00F, 0, 3, 1'b0, 32'hFFFFF00F, 32'h6000, 4'b0011, 32'h0, 1};
    vt[15] = '{1, 1'b0, 2'd2, 1'b0, 32'h8000, 32'h0, 32'hA5A55A5A, 10, 13, 1'b0, 32'hA5A55A5A, 32'h8000, 4'b1111, 32'h0, 11};
    vt[16] = '{1, 1'b1, 2'd0, 1'b0, 32'h9002, 32'h0000003C, 32'h0, 1, 3, 1'b0, 32'h0, 32'h9000, 4'b0100, 32'h3C3C3C3C, 2};
    vt[17] = '{1, 1'b0, 2'd3, 1'b1, 32'h9000, 32'h0, 32'h0, 0, 1, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 0};

    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; rsg[i] = 1'b0; rsz[i] = 2'd0;
      ra[i] = '0; rwd[i] = '0; wreq[i] = 1'b0; rdat[i] = '0;
    end

    // Reset state of both instances.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d req_ready", i), 32'(rdy[i]), 32'd1);
      check($sformatf("rst%0d resp_valid", i), 32'(rsv[i]), 32'd0);
      check($sformatf("rst%0d resp_err", i), 32'(rer[i]), 32'd0);
      check($sformatf("rst%0d read_write", i), 32'({rd[i], wro[i]}), 32'd0);
      check($sformatf("rst%0d address", i), adr[i], 32'd0);
      check($sformatf("rst%0d byteenable", i), 32'(be[i]), 32'd0);
      check($sformatf("rst%0d writedata", i), wd[i], 32'd0);
      check($sformatf("rst%0d resp_rdata", i), rrd[i], 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < int'(NVEC); i++) begin
      run_txn(vt[i].d, vt[i].wr, vt[i].sz, vt[i].sg, vt[i].addr, vt[i].wdata, vt[i].brd,
              vt[i].nwait, 1'(i % 2), o_lat, o_bus, o_err, o_rdata, o_addr, o_be, o_wd,
              o_stable, o_hs);
      e_lat = vt[i].lat; e_bus = vt[i].bus_n; e_err = vt[i].err; e_rdata = vt[i].rdata;
      e_addr = vt[i].baddr; e_be = vt[i].be; e_wd = vt[i].wd;
      compare_all($sformatf("vec%0d", i), vt[i].wr);
    end

    // Reset while a load is stalled in the bus phase.
    rv[0] = 1'b1; rw[0] = 1'b0; rsz[0] = 2'd2; rsg[0] = 1'b0; ra[0] = 32'h3000;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    check("midrst bus1 read", 32'(rd[0]), 32'd1);
    wreq[0] = 1'b1;
    @(posedge clk); #1;
    check("midrst bus2 read", 32'(rd[0]), 32'd1);
    reset = 1'b1;
    rv[0] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rv[0] = 1'b0;
    wreq[0] = 1'b0;
    check("midrst read", 32'(rd[0]), 32'd0);
    check("midrst req_ready", 32'(rdy[0]), 32'd1);
    check("midrst resp_valid", 32'(rsv[0]), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst no_resp", 32'(rsv[0]), 32'd0);
    end
    run_txn(0, 1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h80011234, 0, 1'b0,
            o_lat, o_bus, o_err, o_rdata, o_addr, o_be, o_wd, o_stable, o_hs);
    model(0, 1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h80011234, 0,
          e_lat, e_bus, e_err, e_rdata, e_addr, e_be, e_wd);
    compare_all("after_rst", 1'b0);

    // Randomized transactions against the model.
    for (int k = 0; k < 200; k++) begin
      int d, nw;
      bit wr, sg, nz;
      logic [1:0] sz;
      logic [31:0] a, w, b;
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom);
      sg = 1'($urandom);
      nz = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      w  = $urandom;
      b  = $urandom;
      if (d == 0) nw = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
      else        nw = int'($urandom_range(0, 6));
      run_txn(d, wr, sz, sg, a, w, b, nw, nz,
              o_lat, o_bus, o_err, o_rdata, o_addr, o_be, o_wd, o_stable, o_hs);
      model(d, wr, sz, sg, a, w, b, nw, e_lat, e_bus, e_err, e_rdata, e_addr, e_be, e_wd);
      compare_all($sformatf("rnd%0d", k), wr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
